// File: rtl/mdu_ctrl_if.sv
// rtl/mdu_ctrl_if.sv - issue/result signal bundle between the E stage and the multiply/divide unit
interface mdu_ctrl_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        d_mdu_related;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    // Pipeline side: issues operations and observes HI/LO and the stall request.
    modport master (
        output start, op, a, b, flush, d_mdu_related,
        input  busy, hi, lo, stall
    );

    // MDU side.
    modport slave (
        input  start, op, a, b, flush, d_mdu_related,
        output busy, hi, lo, stall
    );
endinterface

// File: rtl/mdu_ctrl.sv
// rtl/mdu_ctrl.sv - multi-cycle MULT/DIV controller owning the architectural HI/LO registers
module mdu_ctrl #(
    parameter int MUL_CYC = 5,
    parameter int DIV_CYC = 10
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  mdu
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    // The counter is loaded with N-1 so that busy lasts exactly N cycles.
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYC - 1);
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        sgn_q, sgn_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        issue;
    logic [63:0] ext_a, ext_b, product;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b, div_b;
    logic [31:0] quo_mag, rem_mag, quo, rem;

    assign issue = mdu.start & ~mdu.flush & (state_q == S_IDLE);

    // Extending by the latched signedness lets one 64-bit truncated multiply
    // serve both MULT and MULTU.
    assign ext_a   = {{32{sgn_q & a_q[31]}}, a_q};
    assign ext_b   = {{32{sgn_q & b_q[31]}}, b_q};
    assign product = ext_a * ext_b;

    // Signed divide via magnitudes; 0x80000000 / -1 falls out naturally as
    // quotient 0x80000000, remainder 0. A zero divisor is replaced by 1 only
    // to keep the divider defined; its result is never written.
    assign neg_a   = sgn_q & a_q[31];
    assign neg_b   = sgn_q & b_q[31];
    assign mag_a   = neg_a ? -a_q : a_q;
    assign mag_b   = neg_b ? -b_q : b_q;
    assign div_b   = (mag_b == 32'd0) ? 32'd1 : mag_b;
    assign quo_mag = mag_a / div_b;
    assign rem_mag = mag_a % div_b;
    assign quo     = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    assign rem     = neg_a ? -rem_mag : rem_mag;

    // State, counter, operand latches and HI/LO; reset clears all immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            sgn_q   <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next-state: accept issues only when idle, count down, commit at cnt==0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (issue) begin
                    case (mdu.op)
                        3'd0, 3'd1: begin
                            state_d = S_MUL;
                            cnt_d   = MUL_LOAD;
                            a_d     = mdu.a;
                            b_d     = mdu.b;
                            sgn_d   = ~mdu.op[0];
                        end
                        3'd2, 3'd3: begin
                            state_d = S_DIV;
                            cnt_d   = DIV_LOAD;
                            a_d     = mdu.a;
                            b_d     = mdu.b;
                            sgn_d   = ~mdu.op[0];
                        end
                        3'd4:    hi_d = mdu.a;
                        3'd5:    lo_d = mdu.a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    hi_d    = product[63:32];
                    lo_d    = product[31:0];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DIV: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                    if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mdu.busy  = (state_q != S_IDLE);
    assign mdu.hi    = hi_q;
    assign mdu.lo    = lo_q;
    assign mdu.stall = mdu.d_mdu_related &
                       (mdu.busy | (mdu.start & ~mdu.flush & (mdu.op <= 3'd3)));
endmodule
